mem_arbiter: RTL

Sits between the instruction fetch path, the load/store buffer and `memctrl`, and turns three independent memory requesters into one request stream. It picks a winner by fixed priority with an anti-starvation override for instruction fetch, and holds the `memctrl` request until completion. It routes the result back to the winner and enforces the one-cycle post-completion gap that `memctrl` requires. On `clear` it drops speculative reads but lets an in-flight store finish. It also blocks IO-space accesses while the IO buffer is full.

---
 rtl/mem_arbiter.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Merges three memory requesters (instruction fetch, load, store) into a single
// request stream towards memctrl. The winner is chosen by fixed priority
// ST > LD > IF. If fetch has waited through STARVE_LIMIT consecutive LD/ST
// grants, it wins outright. The memctrl request is held until mc_done. The
// result is then routed back to the winner, followed by a mandatory one-cycle
// GAP before the next grant. A clear flushes pending reads but lets an
// in-flight store finish. LD/ST accesses to IO space (addr[17:16] == 2'b11)
// are held off while the IO buffer is full.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   ready               : global enable for new grants
//   clear               : pipeline flush
//   io_buffer_full      : IO output buffer full; blocks IO-space LD/ST
//   if_req/if_addr      : fetch request (always 4 bytes)
//   if_done/if_data     : fetch completion pulse / instruction word
//   ld_req/ld_addr/ld_len : load request, ld_len = bytes-1
//   ld_done/ld_data     : load completion pulse / zero-extended data
//   st_req/st_addr/st_len/st_data : store request
//   st_done             : store completion pulse
//   mc_req/mc_type/mc_addr/mc_len/mc_wdata : request to memctrl (type 1=write)
//   mc_done/mc_rdata    : memctrl completion pulse / read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        clear,
  input  logic        io_buffer_full,
  // instruction fetch
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  // load
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_len,
  output logic        ld_done,
  output logic [31:0] ld_data,
  // store
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_len,
  input  logic [31:0] st_data,
  output logic        st_done,
  // memctrl
  output logic        mc_req,
  output logic        mc_type,
  output logic [31:0] mc_addr,
  output logic [1:0]  mc_len,
  output logic [31:0] mc_wdata,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0]       IO_REGION = 2'b11;
  localparam logic             MC_READ   = 1'b0;
  localparam logic             MC_WRITE  = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_e;
  typedef enum logic [1:0] {G_NONE, G_IF, G_LD, G_ST} gnt_e;

  state_e           state_q,      state_d;
  gnt_e             gnt_q,        gnt_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             mc_req_q,     mc_req_d;
  logic             mc_type_q,    mc_type_d;
  logic [31:0]      mc_addr_q,    mc_addr_d;
  logic [1:0]       mc_len_q,     mc_len_d;
  logic [31:0]      mc_wdata_q,   mc_wdata_d;
  logic             if_done_q,    if_done_d;
  logic             ld_done_q,    ld_done_d;
  logic             st_done_q,    st_done_d;
  logic [31:0]      if_data_q,    if_data_d;
  logic [31:0]      ld_data_q,    ld_data_d;

  logic if_elig, ld_elig, st_elig;
  gnt_e win;

  // Load data is returned zero-extended to the requested byte count.
  function automatic logic [31:0] zext(input logic [31:0] d, input logic [1:0] len);
    case (len)
      2'd0:    zext = {24'b0, d[7:0]};
      2'd1:    zext = {16'b0, d[15:0]};
      2'd2:    zext = {8'b0,  d[23:0]};
      default: zext = d;
    endcase
  endfunction

  // IO-space LD/ST must wait while the IO buffer cannot accept more data.
  always_comb begin
    if_elig = if_req;
    ld_elig = ld_req && !(io_buffer_full && (ld_addr[17:16] == IO_REGION));
    st_elig = st_req && !(io_buffer_full && (st_addr[17:16] == IO_REGION));
  end

  // Starvation override beats the fixed ST > LD > IF order.
  always_comb begin
    win = G_NONE;
    if ((starve_cnt_q == CNT_MAX) && if_elig) win = G_IF;
    else if (st_elig)                         win = G_ST;
    else if (ld_elig)                         win = G_LD;
    else if (if_elig)                         win = G_IF;
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    state_d      = state_q;
    gnt_d        = gnt_q;
    starve_cnt_d = starve_cnt_q;
    mc_req_d     = mc_req_q;
    mc_type_d    = mc_type_q;
    mc_addr_d    = mc_addr_q;
    mc_len_d     = mc_len_q;
    mc_wdata_d   = mc_wdata_q;
    if_data_d    = if_data_q;
    ld_data_d    = ld_data_q;
    if_done_d    = 1'b0;
    ld_done_d    = 1'b0;
    st_done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          mc_req_d = 1'b0;
        end else if (ready && (win != G_NONE)) begin
          state_d  = S_BUSY;
          gnt_d    = win;
          mc_req_d = 1'b1;
          case (win)
            G_IF: begin
              mc_type_d  = MC_READ;
              mc_addr_d  = if_addr;
              mc_len_d   = 2'b11;
              mc_wdata_d = '0;
            end
            G_LD: begin
              mc_type_d  = MC_READ;
              mc_addr_d  = ld_addr;
              mc_len_d   = ld_len;
              mc_wdata_d = '0;
            end
            G_ST: begin
              mc_type_d  = MC_WRITE;
              mc_addr_d  = st_addr;
              mc_len_d   = st_len;
              mc_wdata_d = st_data;
            end
            default: ;
          endcase
          // Count only LD/ST grants that bypass a waiting fetch.
          if ((win == G_IF) || !if_req)    starve_cnt_d = '0;
          else if (starve_cnt_q != CNT_MAX) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end

      S_BUSY: begin
        // A flushed read is abandoned; its late mc_done lands in IDLE and is ignored.
        if (clear && (gnt_q != G_ST)) begin
          state_d  = S_IDLE;
          gnt_d    = G_NONE;
          mc_req_d = 1'b0;
        end else if (mc_done) begin
          state_d  = S_GAP;
          mc_req_d = 1'b0;
          case (gnt_q)
            G_IF: begin
              if_done_d = 1'b1;
              if_data_d = mc_rdata;
            end
            G_LD: begin
              ld_done_d = 1'b1;
              ld_data_d = zext(mc_rdata, mc_len_q);
            end
            G_ST:    st_done_d = 1'b1;
            default: ;
          endcase
        end
      end

      // One dead cycle so memctrl sees a gap and the winner can drop its req.
      S_GAP: begin
        state_d = S_IDLE;
        gnt_d   = G_NONE;
      end

      default: begin
        state_d  = S_IDLE;
        gnt_d    = G_NONE;
        mc_req_d = 1'b0;
      end
    endcase

    if (clear) starve_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= G_NONE;
      starve_cnt_q <= '0;
      mc_req_q     <= 1'b0;
      mc_type_q    <= 1'b0;
      mc_addr_q    <= '0;
      mc_len_q     <= '0;
      mc_wdata_q   <= '0;
      if_done_q    <= 1'b0;
      ld_done_q    <= 1'b0;
      st_done_q    <= 1'b0;
      if_data_q    <= '0;
      ld_data_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      starve_cnt_q <= starve_cnt_d;
      mc_req_q     <= mc_req_d;
      mc_type_q    <= mc_type_d;
      mc_addr_q    <= mc_addr_d;
      mc_len_q     <= mc_len_d;
      mc_wdata_q   <= mc_wdata_d;
      if_done_q    <= if_done_d;
      ld_done_q    <= ld_done_d;
      st_done_q    <= st_done_d;
      if_data_q    <= if_data_d;
      ld_data_q    <= ld_data_d;
    end
  end

  assign mc_req   = mc_req_q;
  assign mc_type  = mc_type_q;
  assign mc_addr  = mc_addr_q;
  assign mc_len   = mc_len_q;
  assign mc_wdata = mc_wdata_q;
  assign if_done  = if_done_q;
  assign ld_done  = ld_done_q;
  assign st_done  = st_done_q;
  assign if_data  = if_data_q;
  assign ld_data  = ld_data_q;

endmodule
